// File: rtl/inst_enc_pkg.sv
// Shared definitions for the instruction encoder: opcodes, word field positions,
// control-bundle packing and the ctrl_decode() reference used by encoder and decoder benches.
package inst_enc_pkg;

    localparam int CTRL_W  = 12;
    localparam int WORD_W  = 32;
    localparam int REG_W   = 6;
    localparam int IMM_W   = 16;

    localparam int OP_LSB  = 28;
    localparam int RD_LSB  = 22;
    localparam int RS_LSB  = 16;
    localparam int RT_LSB  = 10;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JM   = 4'b1010;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    // Packed so that svpc lands in bit 11 and aluop in bits 2:0.
    typedef struct packed {
        logic       svpc;
        logic       brz;
        logic       brn;
        logic       j;
        logic       wai;
        logic       memw;
        logic       memr;
        logic       regw;
        logic       alusrc;
        logic [2:0] aluop;
    } ctrl_t;

    function automatic ctrl_t ctrl_decode(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_NOP:  c = '0;
            OP_ST:   c.memw = 1'b1;
            OP_ADD:  begin c.regw = 1'b1; c.aluop = 3'b001; end
            OP_INC:  begin c.regw = 1'b1; c.alusrc = 1'b1; c.aluop = 3'b001; end
            OP_NEG:  begin c.regw = 1'b1; c.aluop = 3'b010; end
            OP_SUB:  begin c.regw = 1'b1; c.aluop = 3'b011; end
            OP_J:    c.j = 1'b1;
            OP_BRZ:  c.brz = 1'b1;
            OP_JM:   begin c.j = 1'b1; c.memr = 1'b1; end
            OP_BRN:  c.brn = 1'b1;
            OP_LD:   begin c.memr = 1'b1; c.regw = 1'b1; end
            OP_SVPC: begin c.svpc = 1'b1; c.regw = 1'b1; c.alusrc = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic op_assigned(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0010, 4'b1100, 4'b1101: return 1'b0;
            default:                            return 1'b1;
        endcase
    endfunction

    function automatic logic op_has_imm(input logic [3:0] op);
        return (op == OP_INC) || (op == OP_SVPC);
    endfunction

    function automatic logic [WORD_W-1:0] encode_word(
        input logic [3:0]       op,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic [IMM_W-1:0] imm
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[OP_LSB +: 4]     = op;
        w[RD_LSB +: REG_W] = rd;
        w[RS_LSB +: REG_W] = rs;
        if (op_has_imm(op)) begin
            w[IMM_LSB +: IMM_W] = imm;
        end else begin
            w[RT_LSB +: REG_W] = rt;
        end
        return w;
    endfunction

endpackage

// File: rtl/inst_enc_match.sv
// Combinational control-bundle lookup: finds the lowest assigned opcode whose
// decode equals the bundle, or flags the bundle as illegal.
module inst_enc_match
    import inst_enc_pkg::*;
(
    input  logic [CTRL_W-1:0] ctrl,
    output logic              legal,
    output logic [3:0]        op
);

    logic [15:0] hit_s;

    // One comparator per opcode; reserved codes can never hit.
    always_comb begin
        hit_s = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            hit_s[i] = op_assigned(4'(i)) && (ctrl_decode(4'(i)) == ctrl);
        end
    end

    // Descending overwrite leaves the lowest matching opcode.
    always_comb begin
        legal = |hit_s;
        op    = OP_NOP;
        for (int i = 15; i >= 0; i--) begin
            op = hit_s[i] ? 4'(i) : op;
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Re-encodes control bundles into instruction words and writes them sequentially.
// Optional NOP padding of the remaining memory is enabled by INST_ENC_NOP_PAD_EN.
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [11:0]       in_ctrl,
    input  logic [5:0]        in_rd,
    input  logic [5:0]        in_rs,
    input  logic [5:0]        in_rt,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_cnt
);

    // One spare bit so the count can reach DEPTH without wrapping.
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
`ifdef INST_ENC_NOP_PAD_EN
        S_PAD  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t            state_r, state_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic              full_r, full_n;
    logic              err_r, err_n;
    logic [7:0]        err_cnt_r, err_cnt_n;
    logic              mem_we_r, we_n;
    logic [ADDR_W-1:0] mem_addr_r, addr_n;
    logic [31:0]       mem_wdata_r, wdata_n;
    logic              busy_r, busy_n;
    logic              done_r;
    logic              in_ready_r;
    logic              match_legal_s;
    logic [3:0]        match_op_s;
    logic              accept_s;

    inst_enc_match u_match (
        .ctrl  (in_ctrl),
        .legal (match_legal_s),
        .op    (match_op_s)
    );

    assign accept_s = in_valid & in_ready_r;

    // Next-state, counter and write-port decisions.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        full_n    = full_r;
        err_n     = err_r;
        err_cnt_n = err_cnt_r;
        we_n      = 1'b0;
        addr_n    = mem_addr_r;
        wdata_n   = mem_wdata_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n   = S_LOAD;
                    cnt_n     = '0;
                    full_n    = 1'b0;
                    err_n     = 1'b0;
                    err_cnt_n = 8'd0;
                    addr_n    = '0;
                end else begin
                    state_n   = state_r;
                end
            end
            S_LOAD: begin
                if (full_r) begin
                    state_n = S_DONE;
                end else if (accept_s) begin
                    if (match_legal_s) begin
                        we_n    = 1'b1;
                        addr_n  = ADDR_W'(cnt_r);
                        wdata_n = encode_word(match_op_s, in_rd, in_rs, in_rt, in_imm);
                        cnt_n   = cnt_r + CNT_W'(1);
                        full_n  = (cnt_r == LAST_CNT);
                    end else begin
                        err_n     = 1'b1;
                        err_cnt_n = (err_cnt_r == 8'hFF) ? 8'hFF : err_cnt_r + 8'd1;
                    end
                    if (full_n) begin
                        state_n = S_DONE;
                    end else if (in_last) begin
`ifdef INST_ENC_NOP_PAD_EN
                        state_n = S_PAD;
`else
                        state_n = S_DONE;
`endif
                    end else begin
                        state_n = S_LOAD;
                    end
                end else begin
                    state_n = S_LOAD;
                end
            end
`ifdef INST_ENC_NOP_PAD_EN
            S_PAD: begin
                we_n    = 1'b1;
                addr_n  = ADDR_W'(cnt_r);
                wdata_n = 32'h0000_0000;
                cnt_n   = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_CNT) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_PAD;
                end
            end
`endif
            default: begin
                state_n = S_IDLE;
            end
        endcase
`ifdef INST_ENC_NOP_PAD_EN
        busy_n = (state_n == S_LOAD) || (state_n == S_PAD);
`else
        busy_n = (state_n == S_LOAD);
`endif
    end

    // State and every output are registered together so status matches the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= '0;
            full_r      <= 1'b0;
            err_r       <= 1'b0;
            err_cnt_r   <= 8'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'h0000_0000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            full_r      <= full_n;
            err_r       <= err_n;
            err_cnt_r   <= err_cnt_n;
            mem_we_r    <= we_n;
            mem_addr_r  <= addr_n;
            mem_wdata_r <= wdata_n;
            busy_r      <= busy_n;
            done_r      <= (state_n == S_DONE);
            in_ready_r  <= (state_n == S_LOAD) && !full_n;
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign full      = full_r;
    assign err       = err_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder against a behavioural model of the load protocol,
// plus directed literal checks of the encoding, error, full and reset behaviour.
module tb_inst_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_PAD  = 2;
    localparam int PH_DONE = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic [11:0]       in_ctrl = 12'h000;
    logic [5:0]        in_rd = 6'd0;
    logic [5:0]        in_rs = 6'd0;
    logic [5:0]        in_rt = 6'd0;
    logic [15:0]       in_imm = 16'h0000;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              full;
    logic              err;
    logic [7:0]        err_cnt;

    always #5 clk = ~clk;

    inst_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_rd     (in_rd),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .full      (full),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Assigned opcodes and the bundle each one decodes to.
    int          op_tab[12]  = '{0, 3, 4, 5, 6, 7, 8, 9, 10, 11, 14, 15};
    logic [11:0] ctl_tab[12] = '{12'h000, 12'h040, 12'h011, 12'h019, 12'h012, 12'h013,
                                 12'h100, 12'h400, 12'h120, 12'h200, 12'h030, 12'h818};

    int          ph;
    int          m_cnt;
    bit          m_full;
    bit          m_err;
    int          m_errcnt;
    bit          m_acc;
    bit          e_we;
    int          e_addr;
    logic [31:0] e_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [11:0] c);
        for (int i = 0; i < 12; i++) begin
            if (ctl_tab[i] == c) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] model_word(input int op, input int rd, input int rs,
                                                input int rt, input int imm);
        longint w;
        w = (longint'(op) << 28) + (longint'(rd) << 22) + (longint'(rs) << 16);
        if (op == 5 || op == 15) w = w + longint'(imm);
        else                     w = w + (longint'(rt) << 10);
        return w[31:0];
    endfunction

    task automatic model_reset();
        ph = PH_IDLE; m_cnt = 0; m_full = 0; m_err = 0; m_errcnt = 0;
        m_acc = 0; e_we = 0; e_addr = 0; e_wdata = 32'h0;
    endtask

    task automatic model_step();
        int idx;
        e_we  = 0;
        m_acc = 0;
        if (ph == PH_IDLE || ph == PH_DONE) begin
            if (start) begin
                ph = PH_LOAD; m_cnt = 0; m_full = 0; m_err = 0; m_errcnt = 0;
            end
        end else if (ph == PH_LOAD) begin
            if (in_valid && !m_full) begin
                m_acc = 1;
                idx = lookup(in_ctrl);
                if (idx >= 0) begin
                    e_we    = 1;
                    e_addr  = m_cnt;
                    e_wdata = model_word(op_tab[idx], int'(in_rd), int'(in_rs),
                                         int'(in_rt), int'(in_imm));
                    m_cnt++;
                    m_full = (m_cnt == DEPTH);
                end else begin
                    m_err = 1;
                    if (m_errcnt < 255) m_errcnt++;
                end
                if (m_full) ph = PH_DONE;
`ifdef INST_ENC_NOP_PAD_EN
                else if (in_last) ph = PH_PAD;
`else
                else if (in_last) ph = PH_DONE;
`endif
            end
        end else if (ph == PH_PAD) begin
            e_we = 1; e_addr = m_cnt; e_wdata = 32'h0;
            m_cnt++;
            if (m_cnt == DEPTH) ph = PH_DONE;
        end
    endtask

    task automatic check_outputs();
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("in_ready", 32'(in_ready), 32'(ph == PH_LOAD && !m_full));
        chk("busy", 32'(busy), 32'(ph == PH_LOAD || ph == PH_PAD));
        chk("done", 32'(done), 32'(ph == PH_DONE));
        chk("full", 32'(full), 32'(m_full));
        chk("err", 32'(err), 32'(m_err));
        chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
        if (e_we) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_wdata", mem_wdata, e_wdata);
        end
    endtask

    // Compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        start = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_bundle(input logic [11:0] c, input int rd, input int rs, input int rt,
                              input int imm, input bit last);
        in_ctrl = c; in_rd = 6'(rd); in_rs = 6'(rs); in_rt = 6'(rt);
        in_imm = 16'(imm); in_last = last; in_valid = 1'b1;
    endtask

    task automatic rand_inputs();
        bit hold;
        hold = in_valid && !m_acc && ($urandom_range(3) != 0);
        start = (ph == PH_LOAD) ? ($urandom_range(19) == 0) : ($urandom_range(5) == 0);
        if (!hold) begin
            in_valid = ($urandom_range(9) < 6);
            in_last  = ($urandom_range(5) == 0);
            if ($urandom_range(9) < 7) in_ctrl = ctl_tab[$urandom_range(11)];
            else                       in_ctrl = 12'($urandom);
            in_rd  = 6'($urandom);
            in_rs  = 6'($urandom);
            in_rt  = 6'($urandom);
            in_imm = 16'($urandom);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        rst_n = 1'b1;

        // ADD written at address 0, load completes on in_last.
        start = 1'b1; step(); start = 1'b0;
        set_bundle(12'h011, 3, 1, 2, 0, 1'b1); step(); in_valid = 1'b0;
        chk("add_we", 32'(mem_we), 32'd1);
        chk("add_addr", 32'(mem_addr), 32'd0);
        chk("add_word", mem_wdata, 32'h40C10800);
        chk("add_done", 32'(done), 32'd1);
        step();

        // INC carries the immediate instead of rt.
        start = 1'b1; step(); start = 1'b0;
        set_bundle(12'h019, 5, 5, 9, 16'h0007, 1'b1); step(); in_valid = 1'b0;
        chk("inc_word", mem_wdata, 32'h51450007);
        step();

        // brz+brn bundle is rejected without consuming an address.
        start = 1'b1; step(); start = 1'b0;
        set_bundle(12'h600, 1, 2, 3, 0, 1'b0); step();
        chk("ill_we", 32'(mem_we), 32'd0);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_err_cnt", 32'(err_cnt), 32'd1);
        set_bundle(12'h011, 3, 1, 2, 0, 1'b1); step(); in_valid = 1'b0;
        chk("after_ill_we", 32'(mem_we), 32'd1);
        chk("after_ill_addr", 32'(mem_addr), 32'd0);
        step();

        // Five back-to-back bundles: only DEPTH are taken.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_bundle(12'h013, i, i + 1, i + 2, 0, 1'b0); step();
            if (i < 4) chk("fill_addr", 32'(mem_addr), 32'(i));
        end
        in_valid = 1'b0;
        chk("fill_5th_we", 32'(mem_we), 32'd0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(in_ready), 32'd0);
        chk("fill_done", 32'(done), 32'd1);

        // Asynchronous reset while a write is on the port.
        start = 1'b1; step(); start = 1'b0;
        set_bundle(12'h030, 7, 8, 9, 0, 1'b0); step();
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        pulse_reset();
        start = 1'b1; step(); start = 1'b0;
        set_bundle(12'h100, 1, 1, 1, 0, 1'b1); step(); in_valid = 1'b0;
        chk("post_rst_addr", 32'(mem_addr), 32'd0);
        chk("post_rst_word", mem_wdata, 32'h80410400);

        // err_cnt saturates.
        start = 1'b1; step(); start = 1'b0;
        set_bundle(12'h600, 0, 0, 0, 0, 1'b0);
        repeat (260) step();
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);
        in_last = 1'b1; step(); in_valid = 1'b0;
        chk("sat_done", 32'(done), 32'd1);

`ifdef INST_ENC_NOP_PAD_EN
        // Remaining addresses are padded with NOPs.
        start = 1'b1; step(); start = 1'b0;
        set_bundle(12'h011, 3, 1, 2, 0, 1'b1); step(); in_valid = 1'b0;
        chk("pad_first_addr", 32'(mem_addr), 32'd0);
        for (int a = 1; a < DEPTH; a++) begin
            step();
            chk("pad_we", 32'(mem_we), 32'd1);
            chk("pad_addr", 32'(mem_addr), 32'(a));
            chk("pad_word", mem_wdata, 32'h0);
        end
        chk("pad_done", 32'(done), 32'd1);
`endif

        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            if ($urandom_range(399) == 0) pulse_reset();
            else                          step();
        end
        start = 1'b0; in_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the instruction-decode control unit: accepts decoded control bundles plus register and immediate fields, re-encodes them into 32-bit instruction words and writes them sequentially into instruction memory.
- Used by the program loader and self-test path to build programs from control-level descriptions.
- Rejects bundles that no assigned opcode decodes to, and reports them.

Parameters:
- DEPTH, 64, number of instruction-memory words writable per load (≥2).
- ADDR_W, 6, width of mem_addr (2^ADDR_W ≥ DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load at address 0 (ignored unless IDLE or DONE).
- in_valid  in  1  bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- in_ctrl  in  12  {svpc,brz,brn,j,wai,memw,memr,regw,alusrc,aluop[2:0]}.
- in_rd, in_rs, in_rt  in  6 each  register fields.
- in_imm  in  16  immediate, used for INC and SVPC only.
- in_last  in  1  marks the final bundle of the load.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded instruction.
- busy  out  1  state is LOAD or PAD.
- done  out  1  high in DONE.
- full  out  1  DEPTH words accepted.
- err  out  1  sticky: an illegal bundle was seen since start.
- err_cnt  out  8  count of illegal bundles, saturates at 255.

Behaviour:
- Reset: all outputs 0; state IDLE; address and counters 0.
- Opcode map: NOP 0000, ST 0011, ADD 0100, INC 0101, NEG 0110, SUB 0111, J 1000, BRZ 1001, JM 1010, BRN 1011, LD 1110, SVPC 1111. Codes 0001, 0010, 1100, 1101 are reserved and never emitted.
- Word format: op[31:28], rd[27:22], rs[21:16].
  - INC and SVPC: imm[15:0], rt not encoded.
  - All other opcodes: rt[15:10]; bits [9:0] are 0.
  - Fields not used by an opcode are still encoded from the inputs as given.
- Legality: in_ctrl must equal decode(op) for one of the 12 assigned opcodes. Match is tested in ascending opcode order; the first match wins.
- States:
  - IDLE → LOAD on start.
  - LOAD: in_ready = ~full. Handshake = in_valid & in_ready. An accepted bundle is registered, and mem_we/mem_addr/mem_wdata are driven exactly one cycle later (latency 1).
  - LOAD → DONE on an accepted bundle with in_last = 1, or when full asserts.
  - DONE → LOAD on start; that restart clears the address, full, err and err_cnt.
- Legal accept: a write is issued at the current address, then the address increments. full sets when the accepted count reaches DEPTH.
- Illegal accept:
  - No write and no address advance.
  - err sets and err_cnt increments.
  - in_last is still honoured.
- Backpressure: in_ready is low while full or not in LOAD. in_valid may be held, and inputs must then stay stable.
- full with a pending in_valid: the bundle is not taken and the state moves to DONE.
- start while in LOAD or PAD is ignored.
- Reset mid-load: outputs clear immediately (asynchronous). Any write in flight is dropped.
- mem_addr never wraps; writes stop at DEPTH-1.

Optional Feature:
- Macro: INST_ENC_NOP_PAD_EN.
- When defined, in_last (with full low) moves LOAD → PAD instead of DONE. PAD writes 0x00000000 (NOP), one per cycle, at each remaining address through DEPTH-1, then goes to DONE. in_ready is low in PAD.
- When undefined, the PAD state does not exist and in_last goes straight to DONE.

Decomposition:
- Package inst_enc_pkg holds:
  - the opcode localparams (OP_NOP … OP_SVPC);
  - the field bit positions;
  - the 12-bit control-bundle packing;
  - a function ctrl_decode(op) that returns the bundle.
- ctrl_decode is the single source of truth, shared with the decoder's test bench.
- One sub-module, inst_enc_match: combinational bundle-to-{legal, op} lookup. The top level keeps the FSM, counters and output register.

Test Plan:
- start; ADD bundle (regw=1, aluop=001), rd=3, rs=1, rt=2, in_last=1 → next cycle mem_we=1, addr=0, wdata=0x40C10800; then done=1.
- INC bundle (regw=1, alusrc=1, aluop=001), rd=5, rs=5, imm=0x0007 → wdata=0x51450007.
- Bundle with brz=1 and brn=1 → no mem_we, addr stays 0, err=1, err_cnt=1; a following legal bundle is written at addr 0.
- DEPTH=4: five back-to-back valid bundles → four writes at addrs 0–3, full=1, in_ready=0, fifth bundle not taken, done=1.
- rst_n low for 1 cycle during mem_we → all outputs 0 asynchronously; after start, the first write is at addr 0.
- INST_ENC_NOP_PAD_EN, DEPTH=4: one bundle with in_last → its write at addr 0, then NOP writes at addrs 1, 2, 3 on consecutive cycles, then done=1.
